sa9_leaf_stream_fifo: RTL and testbench

Leaf buffering stage for the generated `sa8`/`sa9` instance hierarchy. It sits directly below each `sa9_*` instance and decouples a producer from a consumer with a small valid/ready FIFO. It also reports occupancy and a sticky protocol-error flag, which lets the hierarchy-scaling benches carry real sequential state through every leaf.

---
 rtl/sa9_leaf_stream_fifo_if.sv | 30 +++
 rtl/sa9_leaf_stream_fifo.sv | 84 ++++++++
 tb/tb_sa9_leaf_stream_fifo.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sa9_leaf_stream_fifo_if.sv
// Valid/ready stream bundle for the leaf FIFO: producer side (in_*) and consumer side (out_*).
// master = the environment driving the FIFO, slave = the FIFO itself.
interface sa9_leaf_stream_fifo_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/sa9_leaf_stream_fifo.sv
// Leaf valid/ready FIFO with wrap-bit pointers, registered occupancy and a sticky
// flag for producers that drop or alter an offer while it is being stalled.
module sa9_leaf_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  sa9_leaf_stream_fifo_if.slave  bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wp_q;
  logic [PTR_W-1:0]  rp_q;
  logic [PTR_W-1:0]  count_q;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic              stall_q;
  logic [DATA_W-1:0] held_data_q;
  logic              err_q;
  logic              offer_broken;

  // Full/empty come from the pointers alone so in_ready never depends on out_ready.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[IDX_W-1:0] == rp_q[IDX_W-1:0]) && (wp_q[IDX_W] != rp_q[IDX_W]);

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem[rp_q[IDX_W-1:0]];

  assign push = bus.in_valid && !full;
  assign pop  = bus.out_ready && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PTR_W'(1);
      if (pop)  rp_q <= rp_q + PTR_W'(1);
      count_q <= count_q + PTR_W'(push) - PTR_W'(pop);
    end
  end

  // Storage is deliberately left unreset; a flushed-cycle push is not written.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wp_q[IDX_W-1:0]] <= bus.in_data;
    end
  end

  // A stalled offer must be held unchanged until it is accepted.
  assign offer_broken = stall_q && (!bus.in_valid || (bus.in_data != held_data_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q     <= 1'b0;
      held_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      stall_q     <= bus.in_valid && full;
      held_data_q <= bus.in_data;
      if (offer_broken) err_q <= 1'b1;
    end
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: tb/tb_sa9_leaf_stream_fifo.sv
// Bench for sa9_leaf_stream_fifo: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the FIFO behaviour.
module tb_sa9_leaf_stream_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [2:0] count;
  logic       err;

  always #5 clk = ~clk;

  sa9_leaf_stream_fifo_if #(.DATA_W(DATA_W)) bus ();

  sa9_leaf_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .count (count),
    .err   (err)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_q [$];
  logic [7:0] popped [$];
  bit         model_err;
  bit         prev_stall;
  logic [7:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    model_q.delete();
    model_err  = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
  endtask

  // Advance the reference model by one clock edge using the inputs now applied.
  task automatic model_edge();
    bit full_m;
    bit pu;
    bit po;
    full_m = (model_q.size() == DEPTH);
    pu = bus.in_valid && !full_m;
    po = bus.out_ready && (model_q.size() != 0);
    if (prev_stall && (!bus.in_valid || bus.in_data != prev_data)) model_err = 1'b1;
    prev_stall = bus.in_valid && full_m;
    prev_data  = bus.in_data;
    if (flush) begin
      model_q.delete();
    end else begin
      if (po) void'(model_q.pop_front());
      if (pu) model_q.push_back(bus.in_data);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".count"},     32'(count),         32'(model_q.size()));
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(model_q.size() < DEPTH));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(model_q.size() != 0));
    chk({tag, ".err"},       32'(err),           32'(model_err));
    if (model_q.size() != 0) chk({tag, ".out_data"}, 32'(bus.out_data), 32'(model_q[0]));
  endtask

  task automatic cycle(input string tag);
    if (bus.out_valid && bus.out_ready && !flush) popped.push_back(bus.out_data);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_order [5];
    exp_order = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    do_reset();
    repeat (10) cycle("idle");

    // Fill, stall a fifth offer, then drain in order.
    popped.delete();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = exp_order[i];
      cycle("fill");
    end
    chk("full.count", 32'(count), 32'd4);
    bus.in_data = 8'h55;
    repeat (3) cycle("stall");
    chk("stall.in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    cycle("drain_first");
    cycle("accept_55");
    bus.in_valid = 1'b0;
    repeat (5) cycle("drain");
    chk("order.size", 32'(popped.size()), 32'd5);
    foreach (exp_order[i]) if (i < popped.size()) chk("order.data", 32'(popped[i]), 32'(exp_order[i]));

    // Streaming push/pop across several pointer wraps.
    popped.delete();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = 8'(i);
      cycle("stream");
      chk("stream.count1", 32'(count), 32'd1);
    end
    bus.in_valid = 1'b0;
    cycle("stream_tail");
    chk("stream.size", 32'(popped.size()), 32'd20);
    for (int i = 0; i < 20; i++) if (i < popped.size()) chk("stream.data", 32'(popped[i]), 32'(i));
    chk("stream.err", 32'(err), 32'd0);

    // Flush with concurrent push and pop.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA1 + 8'(i);
      cycle("pre_flush");
    end
    flush = 1'b1;
    bus.in_data   = 8'hEE;
    bus.out_ready = 1'b1;
    cycle("flush");
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.out_valid", 32'(bus.out_valid), 32'd0);
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    cycle("post_flush_idle");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    cycle("post_flush_push");
    bus.in_valid = 1'b0;
    chk("post_flush.head", 32'(bus.out_data), 32'h99);
    bus.out_ready = 1'b1;
    cycle("post_flush_drain");

    // Stalled producer alters its data: sticky error survives flush.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hB0 + 8'(i);
      cycle("err_fill");
    end
    bus.in_data = 8'hA5;
    cycle("err_stall_a");
    cycle("err_stall_b");
    chk("err.held_ok", 32'(err), 32'd0);
    bus.in_data = 8'h5A;
    cycle("err_change");
    chk("err.set", 32'(err), 32'd1);
    bus.in_valid = 1'b0;
    flush = 1'b1;
    cycle("err_flush");
    flush = 1'b0;
    cycle("err_after_flush");
    chk("err.sticky", 32'(err), 32'd1);
    do_reset();
    chk("err.cleared", 32'(err), 32'd0);

    // Asynchronous reset with words in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hC1 + 8'(i);
      cycle("async_fill");
    end
    bus.in_valid = 1'b0;
    chk("async.pre_count", 32'(count), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("async.out_valid", 32'(bus.out_valid), 32'd0);
    chk("async.count", 32'(count), 32'd0);
    chk("async.in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h7E;
    cycle("async_push");
    bus.in_valid = 1'b0;
    chk("async.out_valid_after", 32'(bus.out_valid), 32'd1);
    chk("async.head", 32'(bus.out_data), 32'h7E);
    bus.out_ready = 1'b1;
    cycle("async_drain");

    // Random traffic; producers mostly honour the hold rule, occasionally not.
    for (int n = 0; n < 400; n++) begin
      if (!(prev_stall && $urandom_range(99) >= 3)) begin
        bus.in_valid = ($urandom_range(3) != 0);
        bus.in_data  = 8'($urandom);
      end
      bus.out_ready = ($urandom_range(2) != 0);
      flush = ($urandom_range(49) == 0);
      if ($urandom_range(149) == 0) begin
        flush = 1'b0;
        do_reset();
      end else begin
        cycle("random");
      end
    end
    flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
